// File: rtl/bcd_serial_adder_ctrl.sv
// bcd_serial_adder_ctrl: multi-digit packed-BCD adder that reuses one digit step, LSD first
module bcd_serial_adder_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [4*DIGITS-1:0]   i_a,
    input  logic [4*DIGITS-1:0]   i_b,
    input  logic                  i_cin,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [4*DIGITS-1:0]   o_sum,
    output logic                  o_cout,
    output logic                  o_err
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          r_state, w_next;
    logic [W-1:0]    r_a, r_b, r_sum, w_sum_nxt;
    logic [IW-1:0]   r_idx;
    logic            r_carry, r_err;
    logic [4:0]      w_t;
    logic            w_gt9, w_last, w_bad;
    logic [3:0]      w_digit;

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state and handshake outputs
    always_comb begin
        w_next      = r_state;
        o_in_ready  = (r_state == IDLE);
        o_out_valid = (r_state == DONE);
        case (r_state)
            IDLE:    w_next = i_in_valid ? RUN : IDLE;
            RUN:     w_next = w_last ? DONE : RUN;
            DONE:    w_next = i_out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    // Single-digit BCD step; operands are shifted so the current digit is always at [3:0]
    always_comb begin
        w_t       = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'b0, r_carry};
        w_gt9     = (w_t > 5'd9);
        w_digit   = w_gt9 ? (w_t[3:0] + 4'd6) : w_t[3:0];
        w_bad     = (r_a[3:0] > 4'd9) | (r_b[3:0] > 4'd9);
        w_last    = (int'(r_idx) == DIGITS - 1);
        w_sum_nxt = r_sum;
        for (int i = 0; i < DIGITS; i++)
            w_sum_nxt[4*i +: 4] = (int'(r_idx) == i) ? w_digit : r_sum[4*i +: 4];
    end

    // Operand capture on accept, one digit per cycle while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_err   <= 1'b0;
        end else if (r_state == IDLE && i_in_valid) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= i_cin;
            r_err   <= 1'b0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> 4;
            r_b     <= r_b >> 4;
            r_sum   <= w_sum_nxt;
            r_carry <= w_gt9;
            r_err   <= r_err | w_bad;
            r_idx   <= w_last ? r_idx : r_idx + IW'(1);
        end
    end

    assign o_sum  = r_sum;
    assign o_cout = r_carry;
    assign o_err  = r_err;
endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// tb_bcd_serial_adder_ctrl: randomized and directed checks of the serial BCD adder against a decimal model
module tb_bcd_serial_adder_ctrl;
    localparam int DIGITS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0, b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        cout, err;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_a(a), .i_b(b), .i_cin(cin),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_sum(sum), .o_cout(cout), .o_err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int bcd2dec(input logic [15:0] v);
        return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [15:0] dec2bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    // Valid operands: plain decimal addition. Invalid digits: the per-digit +6 correction rule.
    function automatic void model(input logic [15:0] ma, input logic [15:0] mb, input logic mc,
                                  output logic [15:0] ms, output logic mco, output logic mer);
        int c, t, tot, ad, bd;
        mer = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ad = (int'(ma) >> (4 * i)) & 15;
            bd = (int'(mb) >> (4 * i)) & 15;
            if (ad > 9 || bd > 9) mer = 1'b1;
        end
        if (!mer) begin
            tot = bcd2dec(ma) + bcd2dec(mb) + int'(mc);
            ms  = dec2bcd(tot % 10000);
            mco = (tot >= 10000);
        end else begin
            c  = int'(mc);
            ms = '0;
            for (int i = 0; i < 4; i++) begin
                ad = (int'(ma) >> (4 * i)) & 15;
                bd = (int'(mb) >> (4 * i)) & 15;
                t  = ad + bd + c;
                c  = (t > 9) ? 1 : 0;
                if (t > 9) t = t + 6;
                ms = ms | 16'((t % 16) << (4 * i));
            end
            mco = logic'(c);
        end
    endfunction

    function automatic logic [15:0] rand_bcd();
        logic [15:0] r;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Presents one operand set, waits for the result; lat = cycles from accept edge to out_valid.
    task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                            output int acc_cyc, output int lat);
        int w = 0;
        while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        @(posedge clk);
        acc_cyc = cyc;
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic check_result(input string name, input logic [15:0] ea, input logic [15:0] eb,
                                input logic ec, input int lat);
        logic [15:0] es; logic eco, eer;
        model(ea, eb, ec, es, eco, eer);
        n_total++;
        if (lat !== DIGITS) $display("FAIL %s latency got %0d want %0d", name, lat, DIGITS); else n_pass++;
        n_total++;
        if ({sum, cout, err} !== {es, eco, eer})
            $display("FAIL %s %h+%h+%0d got sum=%h cout=%0d err=%0d want sum=%h cout=%0d err=%0d",
                     name, ea, eb, ec, sum, cout, err, es, eco, eer);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({in_ready, out_valid, sum, cout, err} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0})
            $display("FAIL reset got rdy=%0d vld=%0d sum=%h cout=%0d err=%0d want 1 0 0000 0 0",
                     in_ready, out_valid, sum, cout, err);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        int ac, lat;
        start_op(16'h0999, 16'h0001, 1'b0, ac, lat);
        check_result("d0999", 16'h0999, 16'h0001, 1'b0, lat);
        n_total++;
        if (sum !== 16'h1000) $display("FAIL const0999 got %h want 1000", sum); else n_pass++;
        finish_op();
        start_op(16'h9999, 16'h0001, 1'b0, ac, lat);
        check_result("d9999", 16'h9999, 16'h0001, 1'b0, lat);
        n_total++;
        if ({sum, cout} !== {16'h0000, 1'b1}) $display("FAIL const9999 got %h/%0d want 0000/1", sum, cout); else n_pass++;
        finish_op();
        start_op(16'h1234, 16'h5678, 1'b1, ac, lat);
        check_result("d1234", 16'h1234, 16'h5678, 1'b1, lat);
        n_total++;
        if ({sum, cout, err} !== {16'h6913, 1'b0, 1'b0}) $display("FAIL const1234 got %h/%0d/%0d want 6913/0/0", sum, cout, err); else n_pass++;
        finish_op();
    endtask

    task automatic test_backpressure();
        int ac, lat;
        logic [15:0] s0; logic c0, e0;
        start_op(16'h4567, 16'h8765, 1'b1, ac, lat);
        check_result("bp", 16'h4567, 16'h8765, 1'b1, lat);
        s0 = sum; c0 = cout; e0 = err;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0]; a = 16'h1111 * 16'(i % 9); b = 16'h0001; cin = 1'b1;
            @(posedge clk); #1;
            n_total++;
            if ({out_valid, in_ready, sum, cout, err} !== {1'b1, 1'b0, s0, c0, e0})
                $display("FAIL bp_hold%0d got vld=%0d rdy=%0d sum=%h cout=%0d err=%0d want 1 0 %h %0d %0d",
                         i, out_valid, in_ready, sum, cout, err, s0, c0, e0);
            else n_pass++;
        end
        in_valid = 1'b0;
        finish_op();
        n_total++;
        if ({in_ready, out_valid} !== 2'b10) $display("FAIL bp_release got rdy=%0d vld=%0d want 1 0", in_ready, out_valid); else n_pass++;
    endtask

    task automatic test_invalid();
        int ac, lat;
        start_op(16'h000A, 16'h0000, 1'b0, ac, lat);
        check_result("inv", 16'h000A, 16'h0000, 1'b0, lat);
        n_total++;
        if ({sum, cout, err} !== {16'h0010, 1'b0, 1'b1}) $display("FAIL const000A got %h/%0d/%0d want 0010/0/1", sum, cout, err); else n_pass++;
        finish_op();
        start_op(16'hFFFF, 16'hFFFF, 1'b1, ac, lat);
        check_result("invF", 16'hFFFF, 16'hFFFF, 1'b1, lat);
        n_total++;
        if (sum[3:0] !== 4'h5) $display("FAIL constF_d0 got %h want 5", sum[3:0]); else n_pass++;
        finish_op();
    endtask

    task automatic test_reset_mid_op();
        int ac, lat;
        int w = 0;
        while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
        a = 16'h8888; b = 16'h7777; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({in_ready, out_valid, sum, cout, err} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0})
            $display("FAIL midreset got rdy=%0d vld=%0d sum=%h cout=%0d err=%0d want 1 0 0000 0 0",
                     in_ready, out_valid, sum, cout, err);
        else n_pass++;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_total++;
            if (out_valid !== 1'b0) $display("FAIL midreset_novalid%0d got %0d want 0", i, out_valid); else n_pass++;
        end
        start_op(16'h0005, 16'h0004, 1'b0, ac, lat);
        check_result("after_rst", 16'h0005, 16'h0004, 1'b0, lat);
        n_total++;
        if (sum !== 16'h0009) $display("FAIL const0009 got %h want 0009", sum); else n_pass++;
        finish_op();
    endtask

    task automatic test_random();
        int ac, lat;
        logic [15:0] ra, rb; logic rc;
        for (int k = 0; k < 40; k++) begin
            ra = ($urandom_range(0, 7) == 0) ? 16'($urandom) : rand_bcd();
            rb = rand_bcd();
            rc = 1'($urandom);
            start_op(ra, rb, rc, ac, lat);
            check_result($sformatf("rnd%0d", k), ra, rb, rc, lat);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            finish_op();
        end
    endtask

    task automatic test_back_to_back();
        int ac, lat, prev;
        logic [15:0] ra, rb; logic rc;
        prev = -1;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            ra = rand_bcd(); rb = rand_bcd(); rc = 1'($urandom);
            start_op(ra, rb, rc, ac, lat);
            check_result($sformatf("b2b%0d", k), ra, rb, rc, lat);
            if (prev >= 0) begin
                n_total++;
                if (ac - prev !== DIGITS + 2) $display("FAIL b2b_spacing%0d got %0d want %0d", k, ac - prev, DIGITS + 2); else n_pass++;
            end
            prev = ac;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_backpressure();
        test_invalid();
        test_reset_mid_op();
        test_random();
        test_back_to_back();
        test_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
